pulse_gen_multi: RTL and testbench

//   Multi-channel programmable pulse generator for the user project area. Generalises the

---
 rtl/pulse_gen_multi.sv | 183 ++++++++++++++++++
 tb/tb_pulse_gen_multi.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi -- multi-channel programmable pulse generator.
//
// NUM_CH independent channels, each with its own period (P), high width (H)
// and burst count (N, 0 = continuous). Configuration arrives through a single
// write port addressed by cfg_ch/cfg_sel. start/stop act on channel cfg_ch.
//
// Ports:
//   wb_clk_i   system clock, rising edge
//   wb_rst_i   synchronous active-high reset
//   cfg_we     config write strobe (one cycle per write)
//   cfg_ch     channel addressed by cfg_we/start/stop
//   cfg_sel    0=PERIOD 1=WIDTH 2=BURST 3=reserved (ignored)
//   cfg_data   config write data
//   start      start/restart channel cfg_ch
//   stop       stop channel cfg_ch (wins over start)
//   pulse_out  registered pulse outputs, one per channel
//   busy       channel is running
//   done       one-cycle pulse when a burst completes
//   irq        registered OR of done

// Single channel: IDLE/RUN FSM plus period counter and pulse counter.
//   clk_i/rst_i        clock, synchronous active-high reset
//   wr_p/wr_h/wr_n_i   write strobes for P/H/N, data on wr_data_i
//   start_i/stop_i     already decoded for this channel
//   pulse_o/busy_o/done_o  registered outputs
module pulse_gen_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_p_i,
  input  logic             wr_h_i,
  input  logic             wr_n_i,
  input  logic [CNT_W-1:0] wr_data_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d, h_q, h_d, n_q, n_d;
  logic [CNT_W-1:0] ps_q, ps_d, hs_q, hs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pc_q, pc_d;
  logic             pulse_q, pulse_d, done_q, done_d;
  logic             go, at_wrap, burst_end;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      h_q     <= '0;
      n_q     <= '0;
      ps_q    <= '0;
      hs_q    <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      n_q     <= n_d;
      ps_q    <= ps_d;
      hs_q    <= hs_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  // Next-state / datapath
  always_comb begin
    // A write in the same cycle is visible to start and to a boundary reload.
    p_d = wr_p_i ? wr_data_i : p_q;
    h_d = wr_h_i ? wr_data_i : h_q;
    n_d = wr_n_i ? wr_data_i : n_q;

    go      = start_i && !stop_i && (p_d >= CNT_W'(2));
    at_wrap = (state_q == ST_RUN) && (cnt_q == ps_q - CNT_W'(1));
    // pc_q counts completed periods before this one; ">=" lets a BURST
    // lowered mid-run end the channel at the next boundary.
    burst_end = at_wrap && (n_d != '0) && (pc_q >= n_d - CNT_W'(1));

    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ps_d    = ps_q;
    hs_d    = hs_q;

    if (stop_i) begin
      state_d = ST_IDLE;
    end else if (go) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      pc_d    = '0;
      ps_d    = p_d;
      hs_d    = h_d;
    end else if (state_q == ST_RUN) begin
      if (burst_end) begin
        state_d = ST_IDLE;
      end else if (at_wrap) begin
        cnt_d = '0;
        // Saturate so continuous mode never wraps into a burst end.
        pc_d  = (pc_q == '1) ? pc_q : pc_q + CNT_W'(1);
        ps_d  = p_d;
        hs_d  = h_d;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Output decode: outputs are registered from next-state values so that
  // pulse_out reflects cnt=0 in the first cycle after start.
  always_comb begin
    pulse_d = (state_d == ST_RUN) && (cnt_d < hs_d);
    done_d  = burst_end && !stop_i && !go;
  end

  assign pulse_o = pulse_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = done_q;

endmodule

module pulse_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic              start,
  input  logic              stop,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic              irq
);

  logic [NUM_CH-1:0] hit;
  logic              irq_q, irq_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Channel numbers >= NUM_CH match no instance, so they are ignored.
    assign hit[i] = (cfg_ch == CH_W'(i));

    pulse_gen_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .wr_p_i    (cfg_we && hit[i] && (cfg_sel == 2'd0)),
      .wr_h_i    (cfg_we && hit[i] && (cfg_sel == 2'd1)),
      .wr_n_i    (cfg_we && hit[i] && (cfg_sel == 2'd2)),
      .wr_data_i (cfg_data),
      .start_i   (start && hit[i]),
      .stop_i    (stop && hit[i]),
      .pulse_o   (pulse_out[i]),
      .busy_o    (busy[i]),
      .done_o    (done[i])
    );
  end

  always_comb irq_d = |done;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_pulse_gen_multi.sv
module tb_pulse_gen_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_sel;
  logic [CNT_W-1:0]  cfg_data;
  logic              start, stop;
  logic [NUM_CH-1:0] pulse_out, busy, done;
  logic              irq;

  pulse_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .start(start), .stop(stop),
    .pulse_out(pulse_out), .busy(busy), .done(done), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each channel tracks how far into the current period it
  // is and how many whole periods it has completed.
  int m_p[NUM_CH], m_h[NUM_CH], m_n[NUM_CH];
  bit m_run[NUM_CH];
  int m_pos[NUM_CH], m_cur_p[NUM_CH], m_cur_h[NUM_CH], m_periods[NUM_CH];
  logic [NUM_CH-1:0] e_pulse, e_busy, e_done;
  logic e_irq;

  task automatic model_edge();
    logic [NUM_CH-1:0] nd;
    nd = '0;
    if (wb_rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_p[c] = 0; m_h[c] = 0; m_n[c] = 0; m_run[c] = 0;
        m_pos[c] = 0; m_periods[c] = 0; m_cur_p[c] = 0; m_cur_h[c] = 0;
      end
      e_pulse = '0; e_busy = '0; e_done = '0; e_irq = 1'b0;
      return;
    end
    e_irq = |e_done;
    for (int c = 0; c < NUM_CH; c++) begin
      bit sel;
      sel = (int'(cfg_ch) == c);
      if (cfg_we && sel) begin
        case (cfg_sel)
          2'd0: m_p[c] = int'(cfg_data);
          2'd1: m_h[c] = int'(cfg_data);
          2'd2: m_n[c] = int'(cfg_data);
          default: ;
        endcase
      end
      if (stop && sel) begin
        m_run[c] = 0;
      end else if (start && sel && m_p[c] >= 2) begin
        m_run[c] = 1; m_pos[c] = 0; m_periods[c] = 0;
        m_cur_p[c] = m_p[c]; m_cur_h[c] = m_h[c];
      end else if (m_run[c]) begin
        m_pos[c]++;
        if (m_pos[c] == m_cur_p[c]) begin
          m_periods[c]++;
          if (m_n[c] != 0 && m_periods[c] >= m_n[c]) begin
            m_run[c] = 0;
            nd[c] = 1'b1;
          end else begin
            m_pos[c] = 0; m_cur_p[c] = m_p[c]; m_cur_h[c] = m_h[c];
          end
        end
      end
      e_busy[c]  = m_run[c];
      e_pulse[c] = m_run[c] && (m_pos[c] < m_cur_h[c]);
    end
    e_done = nd;
  endtask

  task automatic tick();
    model_edge();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_sel = 2'(sel); cfg_data = CNT_W'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input int ch);
    start = 1'b1; cfg_ch = CH_W'(ch);
    tick();
    start = 1'b0;
  endtask

  task automatic halt(input int ch);
    stop = 1'b1; cfg_ch = CH_W'(ch);
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    wr(0, 0, 6); wr(0, 1, 2); go(0);
    repeat (4) tick();
    wb_rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({pulse_out, busy, done, irq} !== '0) begin
        miscompares++;
        $display("FAIL reset cyc%0d: got %h want 0", k, {pulse_out, busy, done, irq});
      end
    end
    wb_rst_i = 1'b0;
    go(0);  // config cleared: P=0 so start must be ignored
    vectors++;
    if (busy !== '0 || pulse_out !== '0) begin
      miscompares++;
      $display("FAIL reset_cfg_cleared: busy=%b pulse=%b want 0", busy, pulse_out);
    end
  endtask

  task automatic test_continuous();
    wr(0, 0, 10); wr(0, 1, 3); wr(0, 2, 0); go(0);
    for (int k = 0; k < 30; k++) begin
      vectors++;
      if (pulse_out[0] !== 1'((k % 10) < 3) || busy[0] !== 1'b1 ||
          {pulse_out, busy, done, irq} !== {e_pulse, e_busy, e_done, e_irq}) begin
        miscompares++;
        $display("FAIL continuous k=%0d: got p=%b b=%b all=%h want p=%b model=%h", k,
                 pulse_out[0], busy[0], {pulse_out, busy, done, irq}, (k % 10) < 3,
                 {e_pulse, e_busy, e_done, e_irq});
      end
      tick();
    end
    halt(0);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (pulse_out[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL stop k=%0d: got p=%b b=%b d=%b irq=%b want 0000", k,
                 pulse_out[0], busy[0], done[0], irq);
      end
      tick();
    end
  endtask

  task automatic test_burst();
    int highs = 0;
    wr(1, 0, 5); wr(1, 1, 2); wr(1, 2, 4); go(1);
    for (int k = 0; k < 20; k++) begin
      highs += int'(pulse_out[1]);
      vectors++;
      if (busy[1] !== 1'b1 || done[1] !== 1'b0 || pulse_out[1] !== 1'((k % 5) < 2)) begin
        miscompares++;
        $display("FAIL burst_run k=%0d: got b=%b d=%b p=%b want 1 0 %b", k,
                 busy[1], done[1], pulse_out[1], (k % 5) < 2);
      end
      tick();
    end
    vectors++;
    if (highs != 8) begin
      miscompares++;
      $display("FAIL burst_high_count: got %0d want 8", highs);
    end
    vectors++;
    if (done[1] !== 1'b1 || busy[1] !== 1'b0 || pulse_out[1] !== 1'b0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_done: got d=%b b=%b p=%b irq=%b want 1 0 0 0",
               done[1], busy[1], pulse_out[1], irq);
    end
    tick();
    vectors++;
    if (irq !== 1'b1 || done[1] !== 1'b0 || busy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_irq: got irq=%b d=%b b=%b want 1 0 0", irq, done[1], busy[1]);
    end
    tick();
  endtask

  task automatic test_reconfig();
    wr(2, 0, 8); wr(2, 1, 4); wr(2, 2, 0); go(2);
    for (int k = 0; k < 24; k++) begin
      logic want;
      want = (k < 8) ? 1'(k < 4) : 1'(((k - 8) % 4) < 1);
      vectors++;
      if (pulse_out[2] !== want || busy[2] !== 1'b1 ||
          {pulse_out, busy, done, irq} !== {e_pulse, e_busy, e_done, e_irq}) begin
        miscompares++;
        $display("FAIL reconfig k=%0d: got p=%b all=%h want p=%b model=%h", k,
                 pulse_out[2], {pulse_out, busy, done, irq}, want,
                 {e_pulse, e_busy, e_done, e_irq});
      end
      if (k == 3)      begin cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 2'd0; cfg_data = 16'd4; end
      else if (k == 4) begin cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 2'd1; cfg_data = 16'd1; end
      else cfg_we = 1'b0;
      tick();
    end
    cfg_we = 1'b0;
    halt(2);
  endtask

  task automatic test_edges();
    wr(3, 0, 1); wr(3, 1, 1); go(3);
    vectors++;
    if (busy[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL p1_start: got busy=%b want 0", busy[3]);
    end
    wr(3, 0, 6); wr(3, 1, 0); wr(3, 2, 0); go(3);
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (pulse_out[3] !== 1'b0 || busy[3] !== 1'b1) begin
        miscompares++;
        $display("FAIL h0_low k=%0d: got p=%b b=%b want 0 1", k, pulse_out[3], busy[3]);
      end
      tick();
    end
    halt(3);
    wr(3, 1, 6); go(3);
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (pulse_out[3] !== 1'b1 || busy[3] !== 1'b1) begin
        miscompares++;
        $display("FAIL hp_high k=%0d: got p=%b b=%b want 1 1", k, pulse_out[3], busy[3]);
      end
      tick();
    end
    halt(3);
    start = 1'b1; stop = 1'b1; cfg_ch = 2'd3;
    tick();
    start = 1'b0; stop = 1'b0;
    vectors++;
    if (busy[3] !== 1'b0 || pulse_out[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL start_stop_same: got b=%b p=%b want 0 0", busy[3], pulse_out[3]);
    end
  endtask

  task automatic test_multi();
    int per[NUM_CH] = '{3, 4, 5, 7};
    int wid[NUM_CH] = '{1, 2, 2, 3};
    for (int c = 0; c < NUM_CH; c++) begin
      wr(c, 0, per[c]); wr(c, 1, wid[c]); wr(c, 2, 0);
    end
    for (int c = 0; c < NUM_CH; c++) go(c);
    for (int k = 0; k < 50; k++) begin
      vectors++;
      if ({pulse_out, busy, done, irq} !== {e_pulse, e_busy, e_done, e_irq}) begin
        miscompares++;
        $display("FAIL multi k=%0d: got %h want %h", k, {pulse_out, busy, done, irq},
                 {e_pulse, e_busy, e_done, e_irq});
      end
      start = (k == 24); cfg_ch = 2'd3;  // restart ch3 mid-period
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < NUM_CH; c++) halt(c);
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      vectors++;
      if ({pulse_out, busy, done, irq} !== {e_pulse, e_busy, e_done, e_irq}) begin
        miscompares++;
        $display("FAIL random k=%0d: got %h want %h", k, {pulse_out, busy, done, irq},
                 {e_pulse, e_busy, e_done, e_irq});
      end
      wb_rst_i = ($urandom_range(0, 299) == 0);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_sel  = 2'($urandom_range(0, 3));
      case (cfg_sel)
        2'd0:    cfg_data = CNT_W'($urandom_range(2, 12));
        2'd1:    cfg_data = CNT_W'($urandom_range(0, 14));
        2'd2:    cfg_data = CNT_W'($urandom_range(0, 5));
        default: cfg_data = CNT_W'($urandom);
      endcase
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      tick();
    end
    wb_rst_i = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0;
    e_pulse = '0; e_busy = '0; e_done = '0; e_irq = 1'b0;
    repeat (2) tick();
    wb_rst_i = 1'b0;
    test_reset();
    test_continuous();
    test_burst();
    test_reconfig();
    test_edges();
    test_multi();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
